// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and parity helper.
package uart_pkg;

   localparam int unsigned MAX_DATA_BITS = 9;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   localparam logic [2:0] RX_IDLE   = 3'd0;
   localparam logic [2:0] RX_START  = 3'd1;
   localparam logic [2:0] RX_DATA   = 3'd2;
   localparam logic [2:0] RX_PARITY = 3'd3;
   localparam logic [2:0] RX_STOP   = 3'd4;

   // Expected line parity bit for a word; unused upper bits must be zero.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] word,
                                        input logic [1:0]               mode);
      logic p;
      p = ^word;
      case (mode)
         PAR_ODD:  return ~p;
         PAR_EVEN: return p;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous idle-high input; resets to 1.
module uart_rx_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled framing, parity/framing/break flags,
// valid/ready delivery with overrun pulse when a finished frame cannot be held.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun
);

   localparam int unsigned SAMPLE_W   = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W      = $clog2(DATA_BITS + 1);
   localparam int unsigned MID        = OVERSAMPLE / 2 - 1;
   localparam bit          HAS_PARITY = (PARITY != 0);

   logic rxs;

   uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   logic [2:0]           state_q, state_d;
   logic [SAMPLE_W-1:0]  smp_q, smp_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 pe_p_q, pe_p_d;
   logic                 fe_p_q, fe_p_d;
   logic                 bk_p_q, bk_p_d;
   logic                 done_c;
   logic                 start_mid_c;
   logic                 bit_mid_c;

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 bk_q, bk_d;
   logic                 ovr_q, ovr_d;

   assign start_mid_c = (smp_q == SAMPLE_W'(MID));
   // After the start-bit centre the counter is re-zeroed, so each later centre is a full bit away.
   assign bit_mid_c   = (smp_q == SAMPLE_W'(OVERSAMPLE - 1));

   // Frame FSM; advances only on oversample ticks.
   always_comb begin
      state_d = state_q;
      smp_d   = smp_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      pe_p_d  = pe_p_q;
      fe_p_d  = fe_p_q;
      bk_p_d  = bk_p_q;
      done_c  = 1'b0;
      if (clk_en) begin
         case (state_q)
            RX_IDLE: begin
               if (!rxs) begin
                  state_d = RX_START;
                  smp_d   = '0;
               end
            end
            RX_START: begin
               if (start_mid_c) begin
                  smp_d = '0;
                  if (rxs) begin
                     state_d = RX_IDLE;
                  end else begin
                     state_d = RX_DATA;
                     bit_d   = '0;
                     stop_d  = 1'b0;
                     pe_p_d  = 1'b0;
                     fe_p_d  = 1'b0;
                     bk_p_d  = 1'b0;
                  end
               end else begin
                  smp_d = smp_q + SAMPLE_W'(1);
               end
            end
            RX_DATA: begin
               if (bit_mid_c) begin
                  smp_d   = '0;
                  shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                     bit_d   = '0;
                     stop_d  = 1'b0;
                     bk_p_d  = ~|shift_d;
                     state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end else begin
                  smp_d = smp_q + SAMPLE_W'(1);
               end
            end
            RX_PARITY: begin
               if (bit_mid_c) begin
                  smp_d   = '0;
                  pe_p_d  = (rxs != calc_parity(MAX_DATA_BITS'(shift_q), 2'(PARITY)));
                  bk_p_d  = bk_p_q & ~rxs;
                  state_d = RX_STOP;
               end else begin
                  smp_d = smp_q + SAMPLE_W'(1);
               end
            end
            RX_STOP: begin
               if (bit_mid_c) begin
                  smp_d = '0;
                  if (!rxs) fe_p_d = 1'b1;
                  if (!stop_q) bk_p_d = bk_p_q & ~rxs;
                  if (stop_q == 1'(STOP_BITS - 1)) begin
                     done_c  = 1'b1;
                     state_d = RX_IDLE;
                  end else begin
                     stop_d = 1'b1;
                  end
               end else begin
                  smp_d = smp_q + SAMPLE_W'(1);
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   // Output holding register and handshake; evaluated every clk.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      bk_d    = bk_q;
      ovr_d   = 1'b0;
      if (valid_q && ready) begin
         valid_d = 1'b0;
         pe_d    = 1'b0;
         fe_d    = 1'b0;
         bk_d    = 1'b0;
      end
      if (done_c) begin
         if (!valid_q || ready) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            pe_d    = pe_p_d;
            fe_d    = fe_p_d;
            bk_d    = bk_p_d;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX_IDLE;
         smp_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         pe_p_q  <= 1'b0;
         fe_p_q  <= 1'b0;
         bk_p_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         bk_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         smp_q   <= smp_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         pe_p_q  <= pe_p_d;
         fe_p_q  <= fe_p_d;
         bk_p_q  <= bk_p_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         bk_q    <= bk_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out   = data_q;
   assign valid      = valid_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign break_det  = bk_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations driven with
// hand-built frames; monitors compare every accepted word against the queue.
module tb_uart_rx_param;

   typedef struct packed {
      logic [8:0] data;
      logic       pe;
      logic       fe;
      logic       bd;
   } exp_t;

   logic clk, reset, clk_en;
   logic rx0, rx1, rx2;
   logic ready0, ready1, ready2;
   logic [7:0] dout0, dout1;
   logic [4:0] dout2;
   logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, bd0, bd1, bd2, ov0, ov1, ov2;

   int total = 0;
   int bad   = 0;
   int tick_num = 0;
   int frame_t0 = 0;
   bit frame_active = 0;
   int ovr0 = 0, ovr1 = 0, ovr2 = 0;
   exp_t sb0[$], sb1[$], sb2[$];

   uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .SYNC_STAGES(2)) u0 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx0), .data_out(dout0), .valid(v0),
      .ready(ready0), .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .overrun(ov0));
   uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(8), .SYNC_STAGES(2)) u1 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx1), .data_out(dout1), .valid(v1),
      .ready(ready1), .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .overrun(ov1));
   uart_rx_param #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(8), .SYNC_STAGES(3)) u2 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx2), .data_out(dout2), .valid(v2),
      .ready(ready2), .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .overrun(ov2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oversample tick on every other clk edge.
   initial begin
      clk_en = 1'b0;
      forever begin
         @(negedge clk);
         clk_en = ~clk_en;
      end
   end

   always @(posedge clk) if (clk_en) tick_num <= tick_num + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got word %0h expected none", name, act);
   endtask

   task automatic push(input int idx, input logic [8:0] d, input logic pe, input logic fe, input logic bd);
      exp_t e;
      e.data = d; e.pe = pe; e.fe = fe; e.bd = bd;
      case (idx)
         0: sb0.push_back(e);
         1: sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   task automatic set_rx(input int idx, input logic v);
      case (idx)
         0: rx0 = v;
         1: rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   task automatic sync_tick();
      do @(posedge clk); while (!clk_en);
      @(negedge clk);
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (!clk_en);
      end
      @(negedge clk);
   endtask

   task automatic drive_frame(input int idx, input int os, input logic [8:0] data, input int db,
                              input bit has_par, input logic par_bit, input int nstop,
                              input logic stop1, input logic stop2);
      logic [13:0] bits;
      int n;
      bits = '1;
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < db; i++) begin bits[n] = data[i]; n++; end
      if (has_par) begin bits[n] = par_bit; n++; end
      bits[n] = stop1; n++;
      if (nstop == 2) begin bits[n] = stop2; n++; end
      sync_tick();
      frame_t0 = tick_num;
      frame_active = 1'b1;
      for (int b = 0; b < n; b++) begin
         set_rx(idx, bits[b]);
         wait_ticks(os);
      end
      set_rx(idx, 1'b1);
      frame_active = 1'b0;
      wait_ticks(2 * os);
   endtask

   always begin : mon0
      exp_t e;
      @(negedge clk); #2;
      if (v0 && ready0) begin
         if (sb0.size() == 0) unexpected("u0_word", 32'(dout0));
         else begin
            e = sb0.pop_front();
            check("u0_data", 32'(dout0), 32'(e.data));
            check("u0_parity_err", 32'(pe0), 32'(e.pe));
            check("u0_frame_err", 32'(fe0), 32'(e.fe));
            check("u0_break", 32'(bd0), 32'(e.bd));
         end
      end
      if (ov0) ovr0++;
   end

   always begin : mon1
      exp_t e;
      @(negedge clk); #2;
      if (v1 && ready1) begin
         if (sb1.size() == 0) unexpected("u1_word", 32'(dout1));
         else begin
            e = sb1.pop_front();
            check("u1_data", 32'(dout1), 32'(e.data));
            check("u1_parity_err", 32'(pe1), 32'(e.pe));
            check("u1_frame_err", 32'(fe1), 32'(e.fe));
            check("u1_break", 32'(bd1), 32'(e.bd));
         end
      end
      if (ov1) ovr1++;
   end

   always begin : mon2
      exp_t e;
      @(negedge clk); #2;
      if (v2 && ready2) begin
         if (sb2.size() == 0) unexpected("u2_word", 32'(dout2));
         else begin
            e = sb2.pop_front();
            check("u2_data", 32'(dout2), 32'(e.data));
            check("u2_parity_err", 32'(pe2), 32'(e.pe));
            check("u2_frame_err", 32'(fe2), 32'(e.fe));
            check("u2_break", 32'(bd2), 32'(e.bd));
         end
      end
      if (ov2) ovr2++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #2;
      check("rst_valid0", 32'(v0), 0);
      check("rst_data0", 32'(dout0), 0);
      check("rst_flags0", {29'd0, pe0, fe0, bd0}, 0);
      check("rst_overrun0", 32'(ov0), 0);
      check("rst_valid1", 32'(v1), 0);
      check("rst_valid2", 32'(v2), 0);

      // Basic 8N1 word.
      push(0, 9'hA5, 0, 0, 0);
      drive_frame(0, 16, 9'hA5, 8, 0, 0, 1, 1, 1);

      // Short low glitch then a legal frame.
      sync_tick();
      rx0 = 1'b0;
      wait_ticks(4);
      rx0 = 1'b1;
      wait_ticks(48);
      push(0, 9'h5A, 0, 0, 0);
      drive_frame(0, 16, 9'h5A, 8, 0, 0, 1, 1, 1);

      // Even parity, two stop bits.
      push(1, 9'h03, 1, 0, 0);
      drive_frame(1, 8, 9'h03, 8, 1, 1, 2, 1, 1);
      push(1, 9'h03, 0, 0, 0);
      drive_frame(1, 8, 9'h03, 8, 1, 0, 2, 1, 1);
      push(1, 9'h3C, 0, 1, 0);
      drive_frame(1, 8, 9'h3C, 8, 1, 0, 2, 1, 0);
      push(1, 9'h00, 0, 1, 1);
      drive_frame(1, 8, 9'h00, 8, 1, 0, 2, 0, 1);

      // Five data bits, odd parity.
      push(2, 9'h15, 0, 0, 0);
      drive_frame(2, 8, 9'h15, 5, 1, 0, 1, 1, 1);
      push(2, 9'h15, 1, 0, 0);
      drive_frame(2, 8, 9'h15, 5, 1, 1, 1, 1, 1);
      push(2, 9'h0A, 0, 0, 0);
      drive_frame(2, 8, 9'h0A, 5, 1, 1, 1, 1, 1);

      // Overrun: second frame dropped while first is still held.
      ready0 = 1'b0;
      push(0, 9'h11, 0, 0, 0);
      drive_frame(0, 16, 9'h11, 8, 0, 0, 1, 1, 1);
      drive_frame(0, 16, 9'h22, 8, 0, 0, 1, 1, 1);
      ready0 = 1'b1;
      repeat (4) @(negedge clk);

      // Consumer accepts on the very edge the next frame completes.
      ready0 = 1'b0;
      push(0, 9'h11, 0, 0, 0);
      push(0, 9'h22, 0, 0, 0);
      drive_frame(0, 16, 9'h11, 8, 0, 0, 1, 1, 1);
      fork
         drive_frame(0, 16, 9'h22, 8, 0, 0, 1, 1, 1);
         begin
            wait (frame_active);
            do @(negedge clk); while (tick_num != frame_t0 + 153);
            @(posedge clk);
            @(negedge clk);
            ready0 = 1'b1;
         end
      join
      repeat (4) @(negedge clk);

      // Reset in the middle of data bit 4.
      sync_tick();
      rx0 = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx0 = (8'h96 >> i) & 8'h01;
         wait_ticks(16);
      end
      rx0 = 1'b1;
      wait_ticks(8);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #2;
      check("midreset_valid0", 32'(v0), 0);
      wait_ticks(48);
      check("midreset_idle_valid0", 32'(v0), 0);
      push(0, 9'hC3, 0, 0, 0);
      drive_frame(0, 16, 9'hC3, 8, 0, 0, 1, 1, 1);

      for (int i = 0; i < 3000 && (sb0.size() + sb1.size() + sb2.size()) != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("sb0_left", sb0.size(), 0);
      check("sb1_left", sb1.size(), 0);
      check("sb2_left", sb2.size(), 0);
      check("overrun_u0", ovr0, 1);
      check("overrun_u1", ovr1, 0);
      check("overrun_u2", ovr2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
